// File: rtl/bcd_arb_pkg.sv
// Shared types and helpers for the 10-way BCD-indexed request arbiter.
package bcd_arb_pkg;

  localparam int N_REQ = 10;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [BCD_W-1:0] bcd;
  } enc_t;

  // (a + b) mod 10 for a, b in 0..9; result stays a legal BCD digit
  function automatic logic [BCD_W-1:0] bcd_add_wrap(input logic [BCD_W-1:0] a,
                                                    input logic [BCD_W-1:0] b);
    logic [BCD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (BCD_W+1)'(N_REQ)) s = s - (BCD_W+1)'(N_REQ);
    return s[BCD_W-1:0];
  endfunction

endpackage

// File: rtl/bcd_prio_enc.sv
// Combinational 10-bit priority encoder with rotating start point; rev=1 searches
// downward from index 9 (fixed priority), rev=0 searches upward from ptr with wrap.
module bcd_prio_enc
  import bcd_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [BCD_W-1:0] ptr,
  input  logic             rev,
  output enc_t             win
);

  logic [BCD_W-1:0] idx;

  // Walk the search order backwards so the last hit kept is the first in order.
  always_comb begin
    win.valid = |req;
    win.bcd   = '0;
    idx       = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = rev ? BCD_W'(N_REQ-1-i) : bcd_add_wrap(ptr, BCD_W'(i));
      if (req[idx]) win.bcd = idx;
    end
  end

endmodule

// File: rtl/bcd_req_arbiter.sv
// Arbitrates one shared resource among 10 requesters; grant held until done,
// abandon or timeout, and reported one-hot plus as a BCD digit.
module bcd_req_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  input  logic             rr_mode_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [BCD_W-1:0] gnt_bcd_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

  state_t           state, state_nxt;
  logic [BCD_W-1:0] owner;
  logic [BCD_W-1:0] rr_ptr;
  logic [TW-1:0]    tcnt;
  logic             timeout_q;
  logic             rel_to;
  enc_t             win;

  bcd_prio_enc u_enc (
    .req (req_i),
    .ptr (rr_mode_i ? rr_ptr : BCD_W'(0)),
    .rev (~rr_mode_i),
    .win (win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // done beats abandon beats timeout, so a pulse only fires on a genuine stall
  always_comb begin
    state_nxt = state;
    rel_to    = 1'b0;
    case (state)
      IDLE:    if (win.valid) state_nxt = GRANT;
      GRANT: begin
        if (done_i)              state_nxt = RELEASE;
        else if (!req_i[owner])  state_nxt = RELEASE;
        else if (TIMEOUT != 0 && tcnt == TLAST) begin
          state_nxt = RELEASE;
          rel_to    = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= '0;
      rr_ptr    <= '0;
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= rel_to;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (win.valid) owner <= win.bcd;
        end
        GRANT:   if (tcnt != '1) tcnt <= tcnt + 1'b1;
        RELEASE: rr_ptr <= bcd_add_wrap(owner, BCD_W'(1));
        default: ;
      endcase
    end
  end

  assign gnt_valid_o = (state == GRANT);
  assign gnt_bcd_o   = gnt_valid_o ? owner : '0;
  assign gnt_o       = gnt_valid_o ? (N_REQ'(1) << owner) : '0;
  assign timeout_o   = timeout_q;

endmodule
